// File: rtl/prim_generic_flop_pipe.sv
// Elastic pipeline of Depth valid/ready enable-flop stages with bubble collapse; Depth-cycle latency, stalls hold contents.
// Optional occupancy counter cnt_o is built only when PRIM_FLOP_PIPE_CNT_EN is defined.
module prim_generic_flop_pipe #(
  parameter int               Width      = 32,
  parameter int               Depth      = 2,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [Width-1:0]           data_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [Width-1:0]           data_o
`ifdef PRIM_FLOP_PIPE_CNT_EN
  ,
  output logic [$clog2(Depth+1)-1:0] cnt_o
`endif
);

  if (Depth < 1) begin : g_bad_depth
    $error("prim_generic_flop_pipe: Depth must be >= 1");
  end

  logic [Depth-1:0] r_vld;
  logic [Width-1:0] r_dat [Depth];
  logic [Depth-1:0] w_adv;
  logic [Depth-1:0] w_in_vld;
  logic [Width-1:0] w_in_dat [Depth];

  // A stage may advance if it or any stage downstream of it is empty, or the sink pops.
  for (genvar k = 0; k < Depth; k++) begin : g_adv
    assign w_adv[k] = ready_i | ~(&r_vld[Depth-1:k]);
  end

  assign w_in_vld[0] = valid_i;
  assign w_in_dat[0] = data_i;
  for (genvar k = 1; k < Depth; k++) begin : g_chain
    assign w_in_vld[k] = r_vld[k-1];
    assign w_in_dat[k] = r_dat[k-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld <= '0;
      for (int k = 0; k < Depth; k++) r_dat[k] <= ResetValue;
    end else if (flush_i) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < Depth; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= w_in_vld[k];
          if (w_in_vld[k]) r_dat[k] <= w_in_dat[k];
        end
      end
    end
  end

  assign ready_o = w_adv[0] & ~flush_i & ~rst_i;
  assign valid_o = r_vld[Depth-1] & ~flush_i;
  assign data_o  = r_dat[Depth-1];

`ifdef PRIM_FLOP_PIPE_CNT_EN
  localparam int CntW = $clog2(Depth+1);
  logic [CntW-1:0] r_cnt;
  logic            w_push;
  logic            w_pop;

  assign w_push = valid_i & ready_o;
  assign w_pop  = valid_o & ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (flush_i) begin
      r_cnt <= '0;
    end else if (w_push & ~w_pop) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (w_pop & ~w_push) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

  assign cnt_o = r_cnt;
`endif

  a_stall_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o & ~ready_i) |=> $stable(data_o));

endmodule

// File: tb/tb_prim_generic_flop_pipe.sv
// Directed and scoreboarded random checks of prim_generic_flop_pipe at Width=8, Depth=3.
module tb_prim_generic_flop_pipe;
  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = $clog2(D+1);
  localparam logic [W-1:0] RV = 8'hC3;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         flush_i;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
`ifdef PRIM_FLOP_PIPE_CNT_EN
  logic [CW-1:0] cnt_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] sb [$];

  always #5 clk_i = ~clk_i;

  prim_generic_flop_pipe #(.Width(W), .Depth(D), .ResetValue(RV)) u_dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
`ifdef PRIM_FLOP_PIPE_CNT_EN
    ,
    .cnt_o   (cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs applied just after a rising edge; outputs observed at the following falling edge.
  task automatic drv(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    @(posedge clk_i);
    #1;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    @(negedge clk_i);
  endtask

  task automatic sb_step();
`ifdef PRIM_FLOP_PIPE_CNT_EN
    chk("t6_cnt", 32'(cnt_o), 32'(sb.size()));
`endif
    if (valid_o && ready_i) begin
      chk("t6_pop_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("t6_dat", 32'(data_o), 32'(sb.pop_front()));
    end
    if (valid_i && ready_o) sb.push_back(data_i);
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    repeat (3) @(negedge clk_i);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'(RV));
    chk("rst_ready_o", 32'(ready_o), 32'd0);
`ifdef PRIM_FLOP_PIPE_CNT_EN
    chk("rst_cnt_o", 32'(cnt_o), 32'd0);
`endif
    rst_i = 1'b0;
    #1;
    chk("rst_rel_ready_o", 32'(ready_o), 32'd1);

    // Test 1: unstalled stream, three-cycle latency.
    for (int i = 0; i < 7; i++) begin
      drv(i < 3, W'(8'h11 * (i + 1)), 1'b1, 1'b0);
      chk("t1_valid_o", 32'(valid_o), 32'(i >= 3 && i <= 5));
      if (i >= 3 && i <= 5) chk("t1_data_o", 32'(data_o), 32'(8'h11 * (i - 2)));
      chk("t1_ready_o", 32'(ready_o), 32'd1);
    end

    // Test 2: fill under backpressure, then pop and push together.
    drv(1'b1, 8'hA1, 1'b0, 1'b0); chk("t2_ready_empty", 32'(ready_o), 32'd1);
    drv(1'b1, 8'hA2, 1'b0, 1'b0);
    drv(1'b1, 8'hA3, 1'b0, 1'b0); chk("t2_ready_3rd", 32'(ready_o), 32'd1);
    drv(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("t2_ready_full", 32'(ready_o), 32'd0);
    chk("t2_valid_full", 32'(valid_o), 32'd1);
    chk("t2_data_full", 32'(data_o), 32'hA1);
`ifdef PRIM_FLOP_PIPE_CNT_EN
    chk("t2_cnt_full", 32'(cnt_o), 32'd3);
`endif
    drv(1'b1, 8'hA4, 1'b0, 1'b0);
    chk("t2_ready_hold", 32'(ready_o), 32'd0);
    chk("t2_data_hold", 32'(data_o), 32'hA1);
    drv(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("t2_ready_poppush", 32'(ready_o), 32'd1);
    chk("t2_data_pop1", 32'(data_o), 32'hA1);
    for (int i = 0; i < 3; i++) begin
      drv(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t2_valid_drain", 32'(valid_o), 32'd1);
      chk("t2_data_drain", 32'(data_o), 32'(8'hA2 + i));
    end
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_valid_empty", 32'(valid_o), 32'd0);

    // Test 3: bubble collapse under backpressure.
    drv(1'b1, 8'hAA, 1'b0, 1'b0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    drv(1'b1, 8'hBB, 1'b0, 1'b0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_valid", 32'(valid_o), 32'd1);
    chk("t3_data_aa", 32'(data_o), 32'hAA);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t3_ready_compact", 32'(ready_o), 32'd1);
    chk("t3_data_stall", 32'(data_o), 32'hAA);
`ifdef PRIM_FLOP_PIPE_CNT_EN
    chk("t3_cnt", 32'(cnt_o), 32'd2);
`endif
    drv(1'b0, 8'h00, 1'b1, 1'b0); chk("t3_data_pop_aa", 32'(data_o), 32'hAA);
    drv(1'b0, 8'h00, 1'b1, 1'b0); chk("t3_data_pop_bb", 32'(data_o), 32'hBB);
    chk("t3_valid_bb", 32'(valid_o), 32'd1);
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_valid_empty", 32'(valid_o), 32'd0);
    chk("t3_data_hold_empty", 32'(data_o), 32'hBB);

    // Test 4: flush with two beats in flight and a beat offered.
    drv(1'b1, 8'hC1, 1'b0, 1'b0);
    drv(1'b1, 8'hC2, 1'b0, 1'b0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    drv(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("t4_valid_flush", 32'(valid_o), 32'd0);
    chk("t4_ready_flush", 32'(ready_o), 32'd0);
    drv(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_valid_after", 32'(valid_o), 32'd0);
    chk("t4_ready_after", 32'(ready_o), 32'd1);
    chk("t4_data_retained", 32'(data_o), 32'hC1);
`ifdef PRIM_FLOP_PIPE_CNT_EN
    chk("t4_cnt_after", 32'(cnt_o), 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t4_no_ghost", 32'(valid_o), 32'd0);
    end

    // Test 5: asynchronous reset mid-stream.
    drv(1'b1, 8'h61, 1'b1, 1'b0);
    drv(1'b1, 8'h62, 1'b1, 1'b0);
    drv(1'b1, 8'h63, 1'b1, 1'b0);
    drv(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_valid_pre", 32'(valid_o), 32'd1);
    chk("t5_data_pre", 32'(data_o), 32'h61);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_valid_rst", 32'(valid_o), 32'd0);
    chk("t5_data_rst", 32'(data_o), 32'(RV));
    chk("t5_ready_rst", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("t5_ready_rel", 32'(ready_o), 32'd1);
    drv(1'b1, 8'h5A, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drv(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t5_valid_lat", 32'(valid_o), 32'(i == 3));
      if (i == 3) chk("t5_data_5a", 32'(data_o), 32'h5A);
    end

    // Test 6: random traffic against a scoreboard queue.
    for (int i = 0; i < 10000; i++) begin
      drv(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      sb_step();
    end
    for (int i = 0; i < 8; i++) begin
      drv(1'b0, 8'h00, 1'b1, 1'b0);
      sb_step();
    end
    chk("t6_drained", 32'(sb.size()), 32'd0);
    chk("t6_valid_end", 32'(valid_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
